// File: rtl/prio_q_pkg.sv
// Shared sizing, count limits and FSM state encoding for the priority-queue heap.
// The insert path imports the same package, so both sides agree on word and index widths.
package prio_q_pkg;

    localparam int WIDTH     = 32;
    localparam int AW        = 5;
    localparam int DEPTH     = (1 << AW) - 1;
    localparam int FULL      = DEPTH;
    // Named CNT_EMPTY so it does not collide with the EMPTY state below
    localparam int CNT_EMPTY = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMPTY   = 3'd1,
        RD_ROOT = 3'd2,
        RD_LAST = 3'd3,
        RD_L    = 3'd4,
        RD_R    = 3'd5,
        WRITE   = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/prio_q_child_sel.sv
// Picks the smaller child (left wins ties) and decides whether it must move above v.
// Compares are unsigned.
module prio_q_child_sel
    import prio_q_pkg::*;
(
    input  logic [WIDTH-1:0] lv,
    input  logic [WIDTH-1:0] rv,
    input  logic             right_valid,
    input  logic [WIDTH-1:0] v,
    output logic             pick_right,
    output logic [WIDTH-1:0] cand,
    output logic             move
);

    assign pick_right = right_valid && (rv < lv);
    assign cand       = pick_right ? rv : lv;
    assign move       = (cand < v);

endmodule

// File: rtl/prio_q_heap_extract.sv
// Delete-root engine for the 1-indexed min-heap: returns the root, moves the last
// element to the top and sifts it down one level per RD_L/RD_R pair.
module prio_q_heap_extract
    import prio_q_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop_req,
    output logic             pop_ack,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_empty,
    output logic             busy,
    input  logic [AW-1:0]    heap_count,
    output logic             cnt_dec,
    output logic [AW-1:0]    mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata
);

    state_t           state, state_nx;
    logic [AW-1:0]    h;
    logic [AW-1:0]    n;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] pop_data_q;

    // Child indices carry one extra bit so 2h+1 never wraps for h up to DEPTH
    logic [AW:0]      l_idx, r_idx, n_ext;
    logic             right_valid, pick_right, move;
    logic [WIDTH-1:0] cand;

    assign l_idx       = {h, 1'b0};
    assign r_idx       = {h, 1'b1};
    assign n_ext       = {1'b0, n};
    assign right_valid = (r_idx <= n_ext);
    assign pop_data    = pop_data_q;

    prio_q_child_sel u_child_sel (
        .lv          (lv),
        .rv          (mem_rdata),
        .right_valid (right_valid),
        .v           (v),
        .pick_right  (pick_right),
        .cand        (cand),
        .move        (move)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pop_ack   = 1'b0;
        pop_empty = 1'b0;
        busy      = (state != IDLE);
        cnt_dec   = 1'b0;
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (pop_req) begin
                    state_nx = (heap_count == AW'(CNT_EMPTY)) ? EMPTY : RD_ROOT;
                end
            end
            EMPTY: begin
                pop_ack   = 1'b1;
                pop_empty = 1'b1;
                state_nx  = IDLE;
            end
            RD_ROOT: begin
                mem_raddr = AW'(1);
                state_nx  = RD_LAST;
            end
            RD_LAST: begin
                mem_raddr = heap_count;
                cnt_dec   = 1'b1;
                state_nx  = (heap_count == AW'(1)) ? DONE : RD_L;
            end
            RD_L: begin
                if (l_idx > n_ext) begin
                    state_nx = WRITE;
                end else begin
                    mem_raddr = l_idx[AW-1:0];
                    state_nx  = RD_R;
                end
            end
            RD_R: begin
                if (right_valid) begin
                    mem_raddr = r_idx[AW-1:0];
                end
                if (move) begin
                    mem_we    = 1'b1;
                    mem_waddr = h;
                    mem_wdata = cand;
                    state_nx  = RD_L;
                end else begin
                    state_nx  = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = h;
                mem_wdata = v;
                state_nx  = DONE;
            end
            DONE: begin
                pop_ack  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h          <= '0;
            n          <= '0;
            v          <= '0;
            lv         <= '0;
            pop_data_q <= '0;
        end else begin
            case (state)
                IDLE:    pop_data_q <= '0;
                RD_ROOT: pop_data_q <= mem_rdata;
                RD_LAST: begin
                    v <= mem_rdata;
                    n <= heap_count - AW'(1);
                    h <= AW'(1);
                end
                RD_L: begin
                    if (l_idx <= n_ext) begin
                        lv <= mem_rdata;
                    end
                end
                RD_R: begin
                    if (move) begin
                        h <= pick_right ? r_idx[AW-1:0] : l_idx[AW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_q_heap_extract.sv
// Directed bench for the heap pop engine; the bench owns the heap storage and count.
module tb_prio_q_heap_extract;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pop_req;
    logic        pop_ack;
    logic [31:0] pop_data;
    logic        pop_empty;
    logic        busy;
    logic [4:0]  heap_count;
    logic        cnt_dec;
    logic [4:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem [0:31];
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        cnt_ld;
    logic [4:0]  cnt_val;

    int ncmp = 0;
    int nfail = 0;

    logic [4:0]  wa [0:15];
    logic [31:0] wd [0:15];

    logic [31:0] r_data;
    logic        r_empty;
    int          r_cyc, r_nwr, r_ndec, r_clash;
    int          bad_we, bad_busy;

    always #5 clk = ~clk;

    prio_q_heap_extract dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pop_req    (pop_req),
        .pop_ack    (pop_ack),
        .pop_data   (pop_data),
        .pop_empty  (pop_empty),
        .busy       (busy),
        .heap_count (heap_count),
        .cnt_dec    (cnt_dec),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata)
    );

    assign mem_rdata = (mem_raddr == 5'd0) ? 32'd0 : mem[mem_raddr];

    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (cnt_ld) heap_count <= cnt_val;
        else if (cnt_dec) heap_count <= heap_count - 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic set_count(input logic [4:0] c);
        @(negedge clk);
        cnt_ld = 1'b1; cnt_val = c;
        @(posedge clk); #1;
        cnt_ld = 1'b0;
    endtask

    // Issues one pop from IDLE and watches until pop_ack or a 20-cycle bound.
    task automatic do_pop(output logic [31:0] d, output logic e, output int cyc,
                          output int nwr, output int ndec, output int clash);
        logic got;
        got = 1'b0; d = '0; e = 1'b0; cyc = 99; nwr = 0; ndec = 0; clash = 0;
        @(negedge clk);
        @(negedge clk);
        pop_req = 1'b1;
        @(posedge clk); #1;
        pop_req = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (mem_we) begin
                if (nwr < 16) begin
                    wa[nwr] = mem_waddr;
                    wd[nwr] = mem_wdata;
                end
                nwr++;
            end
            if (cnt_dec) ndec++;
            if (mem_we && cnt_dec) clash++;
            if (pop_ack) begin
                got = 1'b1; cyc = k; d = pop_data; e = pop_empty;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pop_req = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        cnt_ld = 1'b0; cnt_val = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        heap_count = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, pop_ack}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_dec", {31'd0, cnt_dec}, 32'd0);
        chk("rst_data", pop_data, 32'd0);
        chk("rst_raddr", {27'd0, mem_raddr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // empty heap
        set_count(5'd0);
        do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
        chk("empty_cyc", r_cyc, 32'd1);
        chk("empty_flag", {31'd0, r_empty}, 32'd1);
        chk("empty_data", r_data, 32'd0);
        chk("empty_wr", r_nwr, 32'd0);
        chk("empty_dec", r_ndec, 32'd0);

        // single element
        load(5'd1, 32'd7);
        set_count(5'd1);
        do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
        chk("one_data", r_data, 32'd7);
        chk("one_cyc", r_cyc, 32'd3);
        chk("one_flag", {31'd0, r_empty}, 32'd0);
        chk("one_dec", r_ndec, 32'd1);
        chk("one_wr", r_nwr, 32'd0);
        @(negedge clk);
        chk("one_count", {27'd0, heap_count}, 32'd0);

        // three elements
        load(5'd1, 32'd2); load(5'd2, 32'd5); load(5'd3, 32'd9);
        set_count(5'd3);
        do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
        chk("c3_data", r_data, 32'd2);
        chk("c3_cyc", r_cyc, 32'd7);
        chk("c3_nwr", r_nwr, 32'd2);
        chk("c3_clash", r_clash, 32'd0);
        chk("c3_wa0", {27'd0, wa[0]}, 32'd1);
        chk("c3_wd0", wd[0], 32'd5);
        chk("c3_wa1", {27'd0, wa[1]}, 32'd2);
        chk("c3_wd1", wd[1], 32'd9);
        @(negedge clk);
        chk("c3_mem1", mem[1], 32'd5);
        chk("c3_mem2", mem[2], 32'd9);
        chk("c3_count", {27'd0, heap_count}, 32'd2);

        // equal children: left wins
        load(5'd1, 32'd1); load(5'd2, 32'd4); load(5'd3, 32'd4); load(5'd4, 32'd8);
        set_count(5'd4);
        do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
        chk("tie_data", r_data, 32'd1);
        chk("tie_cyc", r_cyc, 32'd7);
        chk("tie_nwr", r_nwr, 32'd2);
        chk("tie_wa0", {27'd0, wa[0]}, 32'd1);
        chk("tie_wd0", wd[0], 32'd4);
        chk("tie_wa1", {27'd0, wa[1]}, 32'd2);
        chk("tie_wd1", wd[1], 32'd8);
        @(negedge clk);
        chk("tie_mem1", mem[1], 32'd4);
        chk("tie_mem2", mem[2], 32'd8);
        chk("tie_mem3", mem[3], 32'd4);
        chk("tie_count", {27'd0, heap_count}, 32'd3);

        // full drain of a sorted (hence valid) 31-entry heap
        for (int i = 1; i <= 31; i++) load(5'(i), 32'(i));
        set_count(5'd31);
        for (int i = 1; i <= 31; i++) begin
            do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
            chk($sformatf("drain_data_%0d", i), r_data, 32'(i));
            chk($sformatf("drain_lat_%0d", i), {31'd0, (r_cyc <= 14)}, 32'd1);
            chk($sformatf("drain_clash_%0d", i), r_clash, 32'd0);
        end
        do_pop(r_data, r_empty, r_cyc, r_nwr, r_ndec, r_clash);
        chk("drain_empty", {31'd0, r_empty}, 32'd1);
        chk("drain_empty_cyc", r_cyc, 32'd1);

        // reset during RD_R
        load(5'd1, 32'd2); load(5'd2, 32'd5); load(5'd3, 32'd9);
        set_count(5'd3);
        @(negedge clk);
        @(negedge clk);
        pop_req = 1'b1;
        @(posedge clk); #1;
        pop_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        chk("mid_we_pre", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ack", {31'd0, pop_ack}, 32'd0);
        chk("mid_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad_we = 0; bad_busy = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (mem_we) bad_we++;
            if (busy) bad_busy++;
        end
        chk("post_rst_we", bad_we, 32'd0);
        chk("post_rst_busy", bad_busy, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
